dbus_arbiter: RTL

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dbus_arbiter
// Purpose  : Two-port data-bus arbiter. Port 0 (page-table walker) and port 1
//            (memory stage) share one downstream data bus. A winner's full
//            request is latched and presented downstream until data_ok
//            returns. Responses are passed back combinationally to the
//            owning port only.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req0_* / req1_*     - upstream requests (valid, addr, size,
//                                  strobe, data)
//            resp0_* / resp1_*   - upstream responses (addr_ok, data_ok, data)
//            dreq_*              - downstream request
//            dresp_*             - downstream response
//            grant, busy         - current owner / transaction in flight
//            timeout_err         - sticky wait-timeout flag
// Params   : RR      - 1 = round-robin, 0 = fixed priority (port 0 wins)
//            TIMEOUT - wait cycles tolerated before timeout_err is raised
// Revision : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [63:0] req0_addr,
    input  logic [2:0]  req0_size,
    input  logic [7:0]  req0_strobe,
    input  logic [63:0] req0_data,
    output logic        resp0_addr_ok,
    output logic        resp0_data_ok,
    output logic [63:0] resp0_data,
    input  logic        req1_valid,
    input  logic [63:0] req1_addr,
    input  logic [2:0]  req1_size,
    input  logic [7:0]  req1_strobe,
    input  logic [63:0] req1_data,
    output logic        resp1_addr_ok,
    output logic        resp1_data_ok,
    output logic [63:0] resp1_data,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [0:0]  c_idle    = 1'b0;
    localparam logic [0:0]  c_busy    = 1'b1;
    localparam logic [15:0] c_timeout = 16'(TIMEOUT);
    localparam logic [15:0] c_wait_max = 16'hFFFF;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic        w_sel;
    logic        w_start;
    logic        w_granted_valid;
    logic [15:0] w_wait_inc;

    logic        r_grant;
    logic        r_last;
    logic        r_abandoned;
    logic        r_timeout_err;
    logic [15:0] r_wait;
    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;

    // Winner selection. With a single requester that requester wins; on a
    // tie round-robin picks the port not served last time.
    always_comb begin
        w_sel = 1'b0;
        if (RR != 0) begin
            if (req0_valid && req1_valid) begin
                w_sel = ~r_last;
            end else begin
                w_sel = req1_valid;
            end
        end else begin
            w_sel = ~req0_valid;
        end
    end

    assign w_start         = (r_state == c_idle) && (req0_valid || req1_valid);
    assign w_granted_valid = r_grant ? req1_valid : req0_valid;
    assign w_wait_inc      = (r_wait == c_wait_max) ? r_wait : r_wait + 16'd1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (req0_valid || req1_valid) w_next_state = c_busy;
            c_busy:  if (dresp_data_ok)            w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy          = (r_state == c_busy);
        dreq_valid    = (r_state == c_busy);
        resp0_data_ok = dresp_data_ok & busy & ~r_grant & ~r_abandoned;
        resp1_data_ok = dresp_data_ok & busy &  r_grant & ~r_abandoned;
        resp0_addr_ok = dresp_addr_ok & busy & ~r_grant & ~r_abandoned;
        resp1_addr_ok = dresp_addr_ok & busy &  r_grant & ~r_abandoned;
    end

    // Latched request, ownership, abandon tracking and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant       <= 1'b0;
            r_last        <= 1'b1;
            r_abandoned   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wait        <= 16'd0;
            r_addr        <= 64'd0;
            r_size        <= 3'd0;
            r_strobe      <= 8'd0;
            r_data        <= 64'd0;
        end else if (w_start) begin
            r_grant     <= w_sel;
            r_last      <= w_sel;
            r_abandoned <= 1'b0;
            r_wait      <= 16'd0;
            r_addr      <= w_sel ? req1_addr   : req0_addr;
            r_size      <= w_sel ? req1_size   : req0_size;
            r_strobe    <= w_sel ? req1_strobe : req0_strobe;
            r_data      <= w_sel ? req1_data   : req0_data;
        end else if (r_state == c_busy) begin
            if (dresp_data_ok) begin
                r_abandoned <= 1'b0;
            end else begin
                // Owner flushed its request: the downstream access still
                // completes, but its response must not be forwarded.
                if (!w_granted_valid) r_abandoned <= 1'b1;
                r_wait <= w_wait_inc;
                if (w_wait_inc > c_timeout) r_timeout_err <= 1'b1;
            end
        end
    end

    assign dreq_addr   = r_addr;
    assign dreq_size   = r_size;
    assign dreq_strobe = r_strobe;
    assign dreq_data   = r_data;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;
    assign resp0_data  = dresp_data;
    assign resp1_data  = dresp_data;

endmodule
`default_nettype wire
